seg_scan_decoder: RTL and testbench

- Receive-side counterpart of DisplayInterface: observes the multiplexed 8-digit seven-segment bus (segment, digit) and reconstructs the displayed 32-bit hex value, decimal points and digit enables.
- Used as a self-checking monitor in display benches, and on-chip for display loopback checks.
- Publishes one coherent snapshot per completed scan frame.

---
 rtl/seg_scan_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a multiplexed 8-digit seven-segment bus and rebuilds
// value/point/enable once per scan frame. Optional build macro: SEG_SCAN_CHANGED_EN.
module seg_scan_decoder #(
   parameter int unsigned MIN_STABLE = 4,
   parameter int unsigned TIMEOUT    = 65536
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  segment,
   input  logic [7:0]  digit,
   output logic [31:0] value,
   output logic [7:0]  point,
   output logic [7:0]  enable,
   output logic        frame_valid,
   output logic        decode_err,
   output logic        changed
);

   typedef enum logic {IDLE, COLLECT} state_e;

   localparam logic [7:0]  STAB_LAST = 8'(MIN_STABLE - 1);
   localparam logic [7:0]  STAB_MAX  = 8'(MIN_STABLE);
   localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT - 1);

   logic [7:0]  seg_m_q, seg_s_q, dig_m_q, dig_s_q;
   logic [15:0] bus, prev_q;
   logic [7:0]  stab_q, stab_d;
   logic [23:0] tmo_q, tmo_d;
   state_e      state_q, state_d;
   logic [2:0]  first_q, first_d;
   logic [31:0] sh_val_q, sh_val_d;
   logic [7:0]  sh_pt_q, sh_pt_d, sh_en_q, sh_en_d;
   logic        err_q, err_d;
   logic [31:0] val_q, val_d;
   logic [7:0]  pt_q, pt_d, en_q, en_d;
   logic        derr_q, derr_d, fv_q, fv_d;

   logic [7:0]  cap_seg, cap_dig, inv;
   logic [2:0]  cap_idx;
   logic [4:0]  dec;
   logic        fire, one_hot, cap, cap_ok, cap_bad;
   logic        tmo_hit, close, pub_zero;

   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      logic [4:0] r;
      r = 5'h00;
      unique case (s)
         7'h3f: r = 5'h10;
         7'h06: r = 5'h11;
         7'h5b: r = 5'h12;
         7'h4f: r = 5'h13;
         7'h66: r = 5'h14;
         7'h6d: r = 5'h15;
         7'h7d: r = 5'h16;
         7'h07: r = 5'h17;
         7'h7f: r = 5'h18;
         7'h6f: r = 5'h19;
         7'h77: r = 5'h1a;
         7'h7c: r = 5'h1b;
         7'h39: r = 5'h1c;
         7'h5e: r = 5'h1d;
         7'h79: r = 5'h1e;
         7'h71: r = 5'h1f;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   assign bus = {seg_s_q, dig_s_q};

   // Capture uses prev_q: it is the value the stability count was measured on.
   assign cap_seg = prev_q[15:8];
   assign cap_dig = prev_q[7:0];
   assign inv     = ~cap_dig;
   assign one_hot = (inv != 8'h00) && ((inv & (inv - 8'd1)) == 8'h00);
   assign dec     = seg_decode(~cap_seg[6:0]);
   assign fire    = (stab_q == STAB_LAST);
   assign cap     = fire && (cap_dig != 8'hff);
   assign cap_ok  = cap && one_hot;
   assign cap_bad = cap && (!one_hot || !dec[4]);
   assign tmo_hit = !cap && (tmo_q == TMO_LAST);

   always_comb begin
      cap_idx = 3'd0;
      for (int k = 0; k < 8; k++)
         if (inv[k]) cap_idx = 3'(k);
   end

   always_comb begin
      stab_d = stab_q;
      if (bus != prev_q) stab_d = 8'd0;
      else if (stab_q != STAB_MAX) stab_d = stab_q + 8'd1;
      tmo_d = (cap || tmo_q == TMO_LAST) ? 24'd0 : tmo_q + 24'd1;
   end

   always_comb begin
      state_d  = state_q;
      first_d  = first_q;
      close    = 1'b0;
      pub_zero = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cap_ok) begin
               first_d = cap_idx;
               state_d = COLLECT;
            end else if (tmo_hit) begin
               pub_zero = 1'b1;
            end
         end
         COLLECT: begin
            if (cap_ok && cap_idx == first_q) begin
               close = 1'b1;
            end else if (tmo_hit) begin
               close   = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      sh_val_d = sh_val_q;
      sh_pt_d  = sh_pt_q;
      sh_en_d  = sh_en_q;
      err_d    = err_q;
      if (close || pub_zero) begin
         sh_val_d = 32'h0;
         sh_pt_d  = 8'h0;
         sh_en_d  = 8'h0;
         err_d    = 1'b0;
      end
      // The wrap digit opens the next frame, so it lands after the clear.
      if (cap_ok) begin
         sh_val_d[{cap_idx, 2'b00} +: 4] = dec[3:0];
         sh_pt_d[cap_idx] = ~cap_seg[7];
         sh_en_d[cap_idx] = 1'b1;
      end
      if (cap_bad) err_d = 1'b1;
   end

   always_comb begin
      fv_d   = close || pub_zero;
      val_d  = val_q;
      pt_d   = pt_q;
      en_d   = en_q;
      derr_d = derr_q;
      if (close) begin
         val_d  = sh_val_q;
         pt_d   = sh_pt_q;
         en_d   = sh_en_q;
         derr_d = err_q;
      end else if (pub_zero) begin
         val_d  = 32'h0;
         pt_d   = 8'h0;
         en_d   = 8'h0;
         derr_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seg_m_q  <= 8'hff;
         seg_s_q  <= 8'hff;
         dig_m_q  <= 8'hff;
         dig_s_q  <= 8'hff;
         prev_q   <= 16'hffff;
         stab_q   <= 8'd0;
         tmo_q    <= 24'd0;
         state_q  <= IDLE;
         first_q  <= 3'd0;
         sh_val_q <= 32'h0;
         sh_pt_q  <= 8'h0;
         sh_en_q  <= 8'h0;
         err_q    <= 1'b0;
         val_q    <= 32'h0;
         pt_q     <= 8'h0;
         en_q     <= 8'h0;
         derr_q   <= 1'b0;
         fv_q     <= 1'b0;
      end else begin
         seg_m_q  <= segment;
         seg_s_q  <= seg_m_q;
         dig_m_q  <= digit;
         dig_s_q  <= dig_m_q;
         prev_q   <= bus;
         stab_q   <= stab_d;
         tmo_q    <= tmo_d;
         state_q  <= state_d;
         first_q  <= first_d;
         sh_val_q <= sh_val_d;
         sh_pt_q  <= sh_pt_d;
         sh_en_q  <= sh_en_d;
         err_q    <= err_d;
         val_q    <= val_d;
         pt_q     <= pt_d;
         en_q     <= en_d;
         derr_q   <= derr_d;
         fv_q     <= fv_d;
      end
   end

   assign value       = val_q;
   assign point       = pt_q;
   assign enable      = en_q;
   assign decode_err  = derr_q;
   assign frame_valid = fv_q;

`ifdef SEG_SCAN_CHANGED_EN
   logic chg_q, chg_d;

   assign chg_d = fv_d && ({val_d, pt_d, en_d} != {val_q, pt_q, en_q});

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) chg_q <= 1'b0;
      else        chg_q <= chg_d;
   end

   assign changed = chg_q;
`else
   assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scan-bus stimulus for seg_scan_decoder,
// mimicking a DisplayInterface that multiplexes 8 digits.
module tb_seg_scan_decoder;

   localparam int MS = 4;
   localparam int TO = 256;
   localparam int DW = 8;

`ifdef SEG_SCAN_CHANGED_EN
   localparam logic CHG = 1'b1;
`else
   localparam logic CHG = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  seg = 8'hff;
   logic [7:0]  dig = 8'hff;
   logic [31:0] value;
   logic [7:0]  point, enable;
   logic        frame_valid, decode_err, changed;

   int n_cmp = 0;
   int n_bad = 0;
   int fv_cnt = 0;
   int cyc = 0;
   int fv_cyc = 0;
   int base, t1, t2;
   logic [31:0] s_val;
   logic [7:0]  s_pt, s_en;
   logic        s_err, s_chg;

   seg_scan_decoder #(.MIN_STABLE(MS), .TIMEOUT(TO)) dut (
      .clock       (clk),
      .reset       (rst_n),
      .segment     (seg),
      .digit       (dig),
      .value       (value),
      .point       (point),
      .enable      (enable),
      .frame_valid (frame_valid),
      .decode_err  (decode_err),
      .changed     (changed)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (frame_valid) begin
         fv_cnt++;
         fv_cyc = cyc;
         s_val  = value;
         s_pt   = point;
         s_en   = enable;
         s_err  = decode_err;
         s_chg  = changed;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] enc(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
            7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
      return t[n];
   endfunction

   // bad: slot shown with code 0x49; two: slot shown with two-hot 8'hfc
   task automatic scan(input logic [31:0] v, input logic [7:0] p,
                       input logic [7:0] e, input int bad, input int two);
      for (int k = 0; k < 8; k++) begin
         logic [6:0] s;
         s = (k == bad) ? 7'h49 : enc(v[4*k +: 4]);
         if (!e[k]) begin
            dig = 8'hff;
            seg = 8'hff;
         end else begin
            dig = (k == two) ? 8'hfc : ~(8'h01 << k);
            seg = {~p[k], ~s};
         end
         repeat (DW) @(negedge clk);
      end
   endtask

   task automatic wait_fv(input string tag, input int maxc);
      int b;
      int n;
      b = fv_cnt;
      n = 0;
      while (fv_cnt == b && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_fv"}, 32'(fv_cnt - b), 32'd1);
   endtask

   task automatic fchk(input string tag, input int b, input logic [31:0] v,
                       input logic [7:0] p, input logic [7:0] e,
                       input logic er, input logic c);
      chk({tag, "_n"}, 32'(fv_cnt - b), 32'd1);
      chk({tag, "_val"}, s_val, v);
      chk({tag, "_pt"}, {24'h0, s_pt}, {24'h0, p});
      chk({tag, "_en"}, {24'h0, s_en}, {24'h0, e});
      chk({tag, "_err"}, {31'h0, s_err}, {31'h0, er});
      chk({tag, "_chg"}, {31'h0, s_chg}, {31'h0, c});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_val", value, 32'h0);
      chk("rst_pt", {24'h0, point}, 32'h0);
      chk("rst_en", {24'h0, enable}, 32'h0);
      chk("rst_fv", {31'h0, frame_valid}, 32'h0);
      chk("rst_err", {31'h0, decode_err}, 32'h0);
      chk("rst_chg", {31'h0, changed}, 32'h0);
      rst_n = 1'b1;

      base = fv_cnt;
      scan(32'h0000ffff, 8'haa, 8'hff, -1, -1);
      chk("A1_n", 32'(fv_cnt - base), 32'd0);
      base = fv_cnt;
      scan(32'h0000ffff, 8'haa, 8'hff, -1, -1);
      fchk("A2", base, 32'h0000ffff, 8'haa, 8'hff, 1'b0, CHG);

      // digit 0 still shows the old value, digits 1..7 the new one
      base = fv_cnt;
      scan(32'h0000005f, 8'haa, 8'hff, -1, -1);
      fchk("M", base, 32'h0000ffff, 8'haa, 8'hff, 1'b0, 1'b0);
      base = fv_cnt;
      scan(32'h00000056, 8'haa, 8'hff, -1, -1);
      fchk("N1", base, 32'h0000005f, 8'haa, 8'hff, 1'b0, CHG);
      base = fv_cnt;
      scan(32'h00000056, 8'haa, 8'hff, -1, -1);
      fchk("N2", base, 32'h00000056, 8'haa, 8'hff, 1'b0, CHG);
      base = fv_cnt;
      scan(32'h00000056, 8'haa, 8'hff, -1, -1);
      fchk("N3", base, 32'h00000056, 8'haa, 8'hff, 1'b0, 1'b0);

      // digits 0..3 only, plus a too-short glitch on digit 5
      base = fv_cnt;
      for (int k = 0; k < 4; k++) begin
         logic [31:0] gv;
         gv = 32'h00000056;
         dig = ~(8'h01 << k);
         seg = {~(k == 1 || k == 3), ~enc(gv[4*k +: 4])};
         repeat (DW) @(negedge clk);
      end
      dig = 8'hdf;
      seg = {1'b1, ~enc(4'he)};
      repeat (MS - 1) @(negedge clk);
      dig = 8'hff;
      seg = 8'hff;
      repeat (4 * DW - (MS - 1)) @(negedge clk);
      fchk("G", base, 32'h00000056, 8'haa, 8'hff, 1'b0, 1'b0);

      base = fv_cnt;
      scan(32'h12345678, 8'h00, 8'hff, 3, -1);
      fchk("D1", base, 32'h00000056, 8'h0a, 8'h0f, 1'b0, CHG);
      base = fv_cnt;
      scan(32'h12345678, 8'h00, 8'hff, -1, -1);
      fchk("D2", base, 32'h12340678, 8'h00, 8'hff, 1'b1, CHG);
      base = fv_cnt;
      scan(32'h12345678, 8'h00, 8'hff, -1, -1);
      fchk("D3", base, 32'h12345678, 8'h00, 8'hff, 1'b0, CHG);

      base = fv_cnt;
      scan(32'h12345678, 8'h00, 8'hff, -1, 2);
      fchk("E1", base, 32'h12345678, 8'h00, 8'hff, 1'b0, 1'b0);
      base = fv_cnt;
      scan(32'h12345678, 8'h00, 8'hff, -1, -1);
      fchk("E2", base, 32'h12345078, 8'h00, 8'hfb, 1'b1, CHG);

      dig = 8'hff;
      seg = 8'hff;
      base = fv_cnt;
      wait_fv("F1", TO + 100);
      fchk("F1", base, 32'h12345678, 8'h00, 8'hff, 1'b0, CHG);
      t1 = fv_cyc;
      base = fv_cnt;
      wait_fv("F2", TO + 20);
      fchk("F2", base, 32'h0, 8'h00, 8'h00, 1'b0, CHG);
      t2 = fv_cyc;
      chk("F2_gap", 32'(t2 - t1), 32'(TO));
      base = fv_cnt;
      wait_fv("F3", TO + 20);
      fchk("F3", base, 32'h0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("F3_gap", 32'(fv_cyc - t2), 32'(TO));

      base = fv_cnt;
      scan(32'h89abcdef, 8'hff, 8'hff, -1, -1);
      chk("H1_n", 32'(fv_cnt - base), 32'd0);
      base = fv_cnt;
      scan(32'h89abcdef, 8'hff, 8'hff, -1, -1);
      fchk("H2", base, 32'h89abcdef, 8'hff, 8'hff, 1'b0, CHG);
      base = fv_cnt;
      scan(32'h89abcdef, 8'hff, 8'h1f, -1, -1);
      fchk("H3", base, 32'h89abcdef, 8'hff, 8'hff, 1'b0, 1'b0);

      #2 rst_n = 1'b0;
      #1;
      chk("R_val", value, 32'h0);
      chk("R_pt", {24'h0, point}, 32'h0);
      chk("R_en", {24'h0, enable}, 32'h0);
      chk("R_fv", {31'h0, frame_valid}, 32'h0);
      chk("R_err", {31'h0, decode_err}, 32'h0);
      chk("R_chg", {31'h0, changed}, 32'h0);
      base = fv_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      scan(32'h76543210, 8'h00, 8'h0f, -1, -1);
      chk("P1_n", 32'(fv_cnt - base), 32'd0);
      scan(32'h76543210, 8'h00, 8'h0f, -1, -1);
      fchk("P2", base, 32'h00003210, 8'h00, 8'h0f, 1'b0, CHG);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
